// File: rtl/comparator_search_ctrl.sv
// Binary-search initiator for an external magnitude comparator: drives Guess as
// operand A, narrows [lo,hi] from the Eq/Gt/Sm flags and reports the found value.
module comparator_search_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          Eq,
    input  logic                          Gt,
    input  logic                          Sm,
    output logic [WIDTH-1:0]              Guess,
    output logic                          busy,
    output logic                          done,
    output logic [WIDTH-1:0]              Result,
    output logic                          Err,
    output logic [$clog2(WIDTH+2)-1:0]    Steps
);

    localparam int unsigned SW = $clog2(WIDTH + 2);
    localparam logic [WIDTH-1:0] LAST      = '1;
    localparam logic [WIDTH-1:0] FIRST     = LAST >> 1;
    localparam logic [SW-1:0]    MAX_STEPS = SW'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lo_q, hi_q, lo_d, hi_d;
    logic [WIDTH-1:0] guess_d, result_d;
    logic [WIDTH-1:0] guess_dec, guess_inc;
    logic [SW-1:0]    steps_d, step_num;
    logic             err_d;
    logic             flags_ok;

    // Midpoint with a carry bit so lo+hi never wraps.
    function automatic logic [WIDTH-1:0] mid(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return WIDTH'(s >> 1);
    endfunction

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        guess_d   = Guess;
        result_d  = Result;
        steps_d   = Steps;
        err_d     = Err;
        step_num  = Steps + SW'(1);
        guess_dec = Guess - WIDTH'(1);
        guess_inc = Guess + WIDTH'(1);
        // Exactly one flag: odd parity and not all three.
        flags_ok  = (Eq ^ Gt ^ Sm) & ~(Eq & Gt & Sm);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = PROBE;
                    lo_d    = '0;
                    hi_d    = LAST;
                    guess_d = FIRST;
                    steps_d = '0;
                    err_d   = 1'b0;
                end
            end
            PROBE: begin
                steps_d = step_num;
                if (!flags_ok) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (Eq) begin
                    state_d  = DONE;
                    result_d = Guess;
                    err_d    = 1'b0;
                end else if (step_num == MAX_STEPS) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (Gt) begin
                    if (Guess == lo_q) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        hi_d    = guess_dec;
                        guess_d = mid(lo_q, guess_dec);
                    end
                end else begin
                    if (Guess == hi_q) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        lo_d    = guess_inc;
                        guess_d = mid(guess_inc, hi_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; busy/done are registered decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            Guess   <= '0;
            Result  <= '0;
            Steps   <= '0;
            Err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            Guess   <= guess_d;
            Result  <= result_d;
            Steps   <= steps_d;
            Err     <= err_d;
            busy    <= (state_d == PROBE);
            done    <= (state_d == DONE);
        end
    end

endmodule
